// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared state type and memory-access encodings for the memory sequencer
package rv_mem_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE, S_ERR} mif_state_t;
  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/rv_mem_if_if.sv
// rv_mem_if_if: request/response bus between the core control FSM and the memory sequencer
interface rv_mem_if_if;
  logic req;
  logic memrw;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic done;
  logic err;
  logic busy;
  modport master(output req, memrw, addr, wdata, input rdata, done, err, busy);
  modport slave(input req, memrw, addr, wdata, output rdata, done, err, busy);
endinterface

// File: rtl/rv_wait_cnt.sv
// rv_wait_cnt: loadable 4-bit down-counter flagging its final wait cycle
module rv_wait_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic [3:0] cnt,
  output logic       last
);
  logic [3:0] cnt_q, cnt_d;
  // Load takes priority over counting down.
  always_comb cnt_d = load ? load_val : en ? cnt_q - 4'd1 : cnt_q;
  // Count register.
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
  assign last = cnt_q == 4'd1;
endmodule

// File: rtl/rv_mem_if.sv
// rv_mem_if: single-port SRAM access sequencer with wait states and alignment/range checks
module rv_mem_if import rv_mem_pkg::*; #(
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 1,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  rv_mem_if_if.slave    bus,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);
  localparam int OFS = $clog2(WORD_BYTES);
  localparam logic [3:0] RDW = 4'(RD_WAIT);
  localparam logic [3:0] WRW = 4'(WR_WAIT);
  if (RD_WAIT < 1 || RD_WAIT > 15 || WR_WAIT < 0 || WR_WAIT > 15 ||
      (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_params
    $error("rv_mem_if: illegal parameters");
  end
  mif_state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic we_q, we_d;
  logic [3:0] cnt, ld_val;
  logic last, bad;
  assign ld_val = we_q == MEM_WR ? WRW : RDW;
  assign bad = bus.addr[OFS-1:0] != '0 || bus.addr[31:OFS] >= (32-OFS)'(DEPTH_WORDS);
  rv_wait_cnt u_cnt (
    .clk(clk),
    .rst(rst),
    .load(state_q == S_ACCESS),
    .en(state_q == S_WAIT),
    .load_val(ld_val),
    .cnt(cnt),
    .last(last)
  );
  // Next state and capture; only IDLE listens to req, so nothing queues.
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    we_d = we_q;
    case (state_q)
      S_IDLE: if (bus.req) begin
        addr_d = bus.addr[AW+OFS-1:OFS];
        wdata_d = bus.wdata;
        we_d = bus.memrw;
        state_d = bad ? S_ERR : S_ACCESS;
      end
      S_ACCESS: state_d = ld_val != '0 ? S_WAIT : S_DONE;
      S_WAIT: state_d = last ? S_DONE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end
  // SRAM data is valid during the first wait cycle, which is when the counter still holds RD_WAIT.
  always_comb rdata_d = (state_q == S_WAIT && we_q == MEM_RD && cnt == RDW) ? mem_rdata : rdata_q;
  // State, capture and read-data registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      rdata_q <= rdata_d;
    end
  assign bus.busy = state_q != S_IDLE;
  assign bus.done = state_q == S_DONE || state_q == S_ERR;
  assign bus.err = state_q == S_ERR;
  assign bus.rdata = rdata_q;
  assign mem_cs = state_q == S_ACCESS;
  assign mem_we = mem_cs & we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_rv_mem_if.sv
// tb_rv_mem_if: randomized scoreboard bench for the memory sequencer
module tb_rv_mem_if;
  import rv_mem_pkg::*;
  localparam int DEPTH = 1024;
  localparam int RDW = 2;
  localparam int WRW = 0;
  localparam int AW = 10;
  logic clk = 0;
  logic rst = 1;
  logic mem_cs, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  rv_mem_if_if bus();
  rv_mem_if #(.DEPTH_WORDS(DEPTH), .RD_WAIT(RDW), .WR_WAIT(WRW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .mem_cs(mem_cs),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic err;
    logic we;
    logic [AW-1:0] widx;
    logic [31:0] wd;
    logic [31:0] rd;
    longint t;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cs_seen = 0;
  logic [31:0] sram [DEPTH] = '{default: '0};
  logic [31:0] ref_mem [DEPTH] = '{default: '0};
  logic [31:0] ref_rd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Synchronous SRAM: read data appears one cycle after the strobe and holds.
  always @(posedge clk)
    if (mem_cs) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else mem_rdata <= sram[mem_addr];
    end

  // Reference: every legal access takes one strobe, errors take none; rdata tracks the last good read.
  function automatic exp_t model(input logic we, input logic [31:0] a, input logic [31:0] d, input longint t0);
    exp_t e;
    logic [31:0] idx;
    idx = a / 4;
    e.we = we;
    e.wd = d;
    e.widx = idx[AW-1:0];
    e.err = (a % 4 != 0) || (idx >= 32'(DEPTH));
    if (e.err) e.t = t0 + 10;
    else if (we) begin
      ref_mem[idx[AW-1:0]] = d;
      e.t = t0 + (WRW + 2) * 10;
    end else begin
      ref_rd = ref_mem[idx[AW-1:0]];
      e.t = t0 + (RDW + 2) * 10;
    end
    e.rd = ref_rd;
    return e;
  endfunction

  // Monitor: checks every strobe against the pending transaction and pops on each done.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (mem_cs) begin
        if (sb.size() == 0 || sb[0].err) flag("unexpected_mem_cs");
        else begin
          chk("mem_we", 32'(mem_we), 32'(sb[0].we));
          chk("mem_addr", 32'(mem_addr), 32'(sb[0].widx));
          if (sb[0].we) chk("mem_wdata", mem_wdata, sb[0].wd);
        end
        cs_seen++;
      end
      if (bus.done) begin
        if (sb.size() == 0) flag("unexpected_done");
        else begin
          e = sb.pop_front();
          chk("err", 32'(bus.err), 32'(e.err));
          chk("rdata", bus.rdata, e.rd);
          chk("done_time", 32'($time), 32'(e.t));
          chk("cs_count", 32'(cs_seen), e.err ? 32'd0 : 32'd1);
        end
        cs_seen = 0;
      end else if (bus.err) flag("err_without_done");
    end
  end

  task automatic wait_idle;
    int n;
    n = 0;
    while (bus.busy) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        flag("idle_timeout");
        break;
      end
    end
  endtask

  task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d);
    wait_idle();
    bus.req = 1;
    bus.memrw = we;
    bus.addr = a;
    bus.wdata = d;
    sb.push_back(model(we, a, d, $time));
    @(negedge clk);
    bus.req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int r;
    bus.req = 0;
    bus.memrw = 0;
    bus.addr = 0;
    bus.wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_mem_cs", 32'(mem_cs), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    rst = 0;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'h0);
    txn(MEM_WR, 32'h10, 32'hDEADBEEF);
    txn(MEM_RD, 32'h10, 32'h0);
    txn(MEM_WR, 32'h8, 32'h1234);
    txn(MEM_RD, 32'h6, 32'h0);
    txn(MEM_WR, 32'(4 * DEPTH), 32'h55);
    wait_idle();
    bus.req = 1;
    bus.memrw = MEM_RD;
    bus.addr = 32'h10;
    for (int k = 0; k < 3; k++) sb.push_back(model(MEM_RD, 32'h10, 32'h0, $time + k * (RDW + 3) * 10));
    repeat (2 * (RDW + 3) + 1) @(negedge clk);
    bus.req = 0;
    txn(MEM_WR, 32'h20, 32'hA5A5);
    @(negedge clk);
    chk("done_cycle", 32'(bus.done), 32'h1);
    bus.req = 1;
    bus.memrw = MEM_RD;
    bus.addr = 32'h10;
    @(negedge clk);
    bus.req = 0;
    chk("busy_after_done_req", 32'(bus.busy), 32'h0);
    @(negedge clk);
    chk("busy_after_done_req2", 32'(bus.busy), 32'h0);
    wait_idle();
    bus.req = 1;
    bus.memrw = MEM_RD;
    bus.addr = 32'h10;
    sb.push_back(model(MEM_RD, 32'h10, 32'h0, $time));
    @(negedge clk);
    bus.req = 0;
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_mem_cs", 32'(mem_cs), 32'h0);
    chk("abort_done", 32'(bus.done), 32'h0);
    chk("abort_rdata", bus.rdata, 32'h0);
    sb.delete();
    cs_seen = 0;
    ref_rd = '0;
    @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk("post_abort_busy", 32'(bus.busy), 32'h0);
    chk("post_abort_rdata", bus.rdata, 32'h0);
    txn(MEM_RD, 32'h10, 32'h0);
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) a = 32'(((r == 0) ? 1023 : $urandom_range(0, 15)) * 4);
      else if (r == 7) a = ($urandom_range(0, 1023) << 2) | $urandom_range(1, 3);
      else a = ($urandom & 32'hFFFF_FFFC) | 32'h1000;
      txn(logic'($urandom_range(0, 1)), a, $urandom);
    end
    wait_idle();
    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
